// File: rtl/invaders_pkg.sv
// Shared grid geometry and bullet FSM encoding for the
// player bullet and the invaders block.
package invaders_pkg;

   localparam int X_W      = 5;
   localparam int Y_W      = 4;
   localparam int PARK_Y   = 15;
   localparam int LAUNCH_Y = 14;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLYING   = 2'd1,
      COOLDOWN = 2'd2
   } bullet_state_t;

endpackage

// File: rtl/bullet_tick_timer.sv
// Restartable movement-tick divider; o_tick is high on the
// last count of each TICK_DIV-cycle period while enabled.
module bullet_tick_timer #(
   parameter int TICK_DIV = 600000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic o_tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

   assign o_tick = enable && (cnt == LAST);

endmodule

// File: rtl/bullet_ctrl.sv
// Player bullet: launch on fire edge, climb one row per tick,
// retire on hit or top exit, then cool down before next shot.
module bullet_ctrl #(
   parameter int X_W            = invaders_pkg::X_W,
   parameter int Y_W            = invaders_pkg::Y_W,
   parameter int X_MAX          = 31,
   parameter int LAUNCH_Y       = invaders_pkg::LAUNCH_Y,
   parameter int PARK_Y         = invaders_pkg::PARK_Y,
   parameter int TICK_DIV       = 600000,
   parameter int COOLDOWN_TICKS = 8
) (
   input  logic           i_clk_36MHz,
   input  logic           i_reset_n,
   input  logic           i_fire,
   input  logic [X_W-1:0] i_player_x,
   input  logic           i_hit,
   output logic [X_W-1:0] o_bullet_x,
   output logic [Y_W-1:0] o_bullet_y,
   output logic           o_bullet_active,
   output logic           o_shot_fired,
   output logic           o_miss
);

   localparam logic [1:0] ST_IDLE     = invaders_pkg::IDLE;
   localparam logic [1:0] ST_FLYING   = invaders_pkg::FLYING;
   localparam logic [1:0] ST_COOLDOWN = invaders_pkg::COOLDOWN;

   localparam int CD_W =
      (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
   localparam logic [CD_W-1:0] CD_LAST =
      CD_W'((COOLDOWN_TICKS > 0) ? COOLDOWN_TICKS - 1 : 0);

   localparam logic [X_W-1:0] X_LIM  = X_W'(X_MAX);
   localparam logic [Y_W-1:0] Y_PARK = Y_W'(PARK_Y);
   localparam logic [Y_W-1:0] Y_LNCH = Y_W'(LAUNCH_Y);

   logic [1:0]      state;
   logic [CD_W-1:0] cd_cnt;
   logic            fire_prev;
   logic            fire_edge;
   logic            launch;
   logic            tick;
   logic [X_W-1:0]  x_clamped;

   assign fire_edge = i_fire && !fire_prev;
   assign launch    = (state == ST_IDLE) && fire_edge;
   assign x_clamped = (i_player_x > X_LIM) ? X_LIM : i_player_x;

   bullet_tick_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk     (i_clk_36MHz),
      .reset_n (i_reset_n),
      .clear   (launch),
      .enable  (state != ST_IDLE),
      .o_tick  (tick)
   );

   always_ff @(posedge i_clk_36MHz or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state           <= ST_IDLE;
         o_bullet_x      <= '0;
         o_bullet_y      <= Y_PARK;
         o_bullet_active <= 1'b0;
         o_shot_fired    <= 1'b0;
         o_miss          <= 1'b0;
         cd_cnt          <= '0;
         fire_prev       <= 1'b0;
      end else begin
         fire_prev    <= i_fire;
         o_shot_fired <= 1'b0;
         o_miss       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (fire_edge) begin
                  state           <= ST_FLYING;
                  o_bullet_active <= 1'b1;
                  o_bullet_y      <= Y_LNCH;
                  o_bullet_x      <= x_clamped;
                  o_shot_fired    <= 1'b1;
               end
            end
            ST_FLYING: begin
               // a hit outranks a coincident tick
               if (i_hit || (tick && o_bullet_y == '0)) begin
                  state           <= ST_COOLDOWN;
                  o_bullet_active <= 1'b0;
                  o_bullet_y      <= Y_PARK;
                  o_bullet_x      <= '0;
                  o_miss          <= !i_hit;
                  cd_cnt          <= '0;
               end else if (tick) begin
                  o_bullet_y <= o_bullet_y - Y_W'(1);
               end
            end
            ST_COOLDOWN: begin
               if (COOLDOWN_TICKS == 0 || (tick && cd_cnt == CD_LAST)) begin
                  state  <= ST_IDLE;
                  cd_cnt <= '0;
               end else if (tick) begin
                  cd_cnt <= cd_cnt + CD_W'(1);
               end
            end
            default: begin
               state           <= ST_IDLE;
               o_bullet_active <= 1'b0;
               o_bullet_y      <= Y_PARK;
               o_bullet_x      <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed bench for bullet_ctrl with TICK_DIV=4,
// COOLDOWN_TICKS=2, X_MAX=19.
module tb_bullet_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       fire;
   logic       hit;
   logic [4:0] px;
   logic [4:0] bx;
   logic [3:0] by;
   logic       act;
   logic       shot;
   logic       miss;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bullet_ctrl #(
      .X_MAX          (19),
      .TICK_DIV       (4),
      .COOLDOWN_TICKS (2)
   ) dut (
      .i_clk_36MHz     (clk),
      .i_reset_n       (rst_n),
      .i_fire          (fire),
      .i_player_x      (px),
      .i_hit           (hit),
      .o_bullet_x      (bx),
      .o_bullet_y      (by),
      .o_bullet_active (act),
      .o_shot_fired    (shot),
      .o_miss          (miss)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int seen;
      int shots;
      int rel;

      rst_n = 1'b0;
      fire  = 1'b0;
      hit   = 1'b0;
      px    = '0;
      cyc(3);
      rst_n = 1'b1;
      chk("rst_x", 32'(bx), 0);
      chk("rst_y", 32'(by), 15);
      chk("rst_act", 32'(act), 0);
      chk("rst_shot", 32'(shot), 0);
      chk("rst_miss", 32'(miss), 0);

      seen = 0;
      for (int i = 0; i < 20; i++) begin
         hit = i[0];
         cyc(1);
         if (act || shot || miss || by != 4'd15 || bx != 5'd0) seen++;
      end
      hit = 1'b0;
      chk("idle_quiet", 32'(seen), 0);

      // launch at x=7, fire held
      px   = 5'd7;
      fire = 1'b1;
      cyc(1);
      chk("launch_shot", 32'(shot), 1);
      chk("launch_act", 32'(act), 1);
      chk("launch_x", 32'(bx), 7);
      chk("launch_y", 32'(by), 14);
      cyc(1);
      chk("shot_one_cycle", 32'(shot), 0);
      cyc(2);
      chk("y_before_tick", 32'(by), 14);
      cyc(1);
      chk("y_first_dec", 32'(by), 13);
      shots = 0;
      for (int i = 5; i < 50; i++) begin
         cyc(1);
         if (shot) shots++;
      end
      fire = 1'b0;
      chk("held_fire_shots", 32'(shots), 0);

      rel = 49;
      while (!miss && rel < 120) begin
         cyc(1);
         rel++;
      end
      chk("miss_time", 32'(rel), 60);
      chk("miss_y", 32'(by), 15);
      chk("miss_act", 32'(act), 0);
      chk("miss_x", 32'(bx), 0);
      cyc(1);
      chk("miss_one_cycle", 32'(miss), 0);

      // fire during cooldown is dropped
      cyc(3);
      fire = 1'b1;
      cyc(1);
      chk("cd_fire_shot", 32'(shot), 0);
      chk("cd_fire_act", 32'(act), 0);
      fire = 1'b0;
      cyc(6);
      px   = 5'd3;
      fire = 1'b1;
      cyc(1);
      chk("relaunch_shot", 32'(shot), 1);
      chk("relaunch_x", 32'(bx), 3);
      chk("relaunch_y", 32'(by), 14);
      fire = 1'b0;

      rel = 0;
      while (by != 4'd10 && rel < 40) begin
         cyc(1);
         rel++;
      end
      chk("reach_y10", 32'(rel), 16);
      hit = 1'b1;
      cyc(1);
      hit = 1'b0;
      chk("hit_act", 32'(act), 0);
      chk("hit_y", 32'(by), 15);
      chk("hit_x", 32'(bx), 0);
      chk("hit_no_miss", 32'(miss), 0);

      // clamp, hold, and hit coinciding with a tick
      cyc(20);
      px   = 5'd31;
      fire = 1'b1;
      cyc(1);
      chk("clamp_act", 32'(act), 1);
      chk("clamp_x", 32'(bx), 19);
      fire = 1'b0;
      px   = 5'd0;
      cyc(2);
      chk("x_hold", 32'(bx), 19);
      cyc(1);
      chk("pre_tick_y", 32'(by), 14);
      hit = 1'b1;
      cyc(1);
      hit = 1'b0;
      chk("hit_tick_act", 32'(act), 0);
      chk("hit_tick_y", 32'(by), 15);
      chk("hit_tick_miss", 32'(miss), 0);

      // asynchronous reset mid-flight
      cyc(20);
      px   = 5'd5;
      fire = 1'b1;
      cyc(1);
      fire = 1'b0;
      chk("rf_launch_act", 32'(act), 1);
      rel = 0;
      while (by != 4'd9 && rel < 40) begin
         cyc(1);
         rel++;
      end
      chk("reach_y9", 32'(rel), 20);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_act", 32'(act), 0);
      chk("arst_y", 32'(by), 15);
      chk("arst_x", 32'(bx), 0);
      chk("arst_miss", 32'(miss), 0);
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      fire = 1'b1;
      cyc(1);
      fire = 1'b0;
      chk("post_rst_shot", 32'(shot), 1);
      chk("post_rst_act", 32'(act), 1);
      chk("post_rst_x", 32'(bx), 5);
      chk("post_rst_y", 32'(by), 14);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
